vco_period_scheduler: RTL



---
 rtl/vco_sched_pkg.sv | 31 +++
 rtl/vco_period_scheduler_rr_pick.sv | 33 +++
 rtl/vco_period_scheduler.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/vco_sched_pkg.sv
// Purpose: shared constants, FSM encodings and helpers for the VCO period scheduler.
// Latency: n/a (package only).
// Backpressure: n/a.
package vco_sched_pkg;

    // FSM encodings kept as plain constants so legacy tools can consume them
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Control-voltage range accepted by the period engine
    localparam logic signed [15:0] V_MIN = 16'sd1;
    localparam logic signed [15:0] V_MAX = 16'sd32766;
    localparam logic signed [15:0] VCC   = 16'sd16384;

    // Width of a channel index; never narrower than one bit
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Clamp a signed control voltage into the engine's legal input range
    function automatic logic [15:0] clamp_v(input logic signed [15:0] v);
        if (v < V_MIN) begin
            return V_MIN;
        end else if (v > V_MAX) begin
            return V_MAX;
        end
        return v;
    endfunction

endpackage

// File: rtl/vco_period_scheduler_rr_pick.sv
// Purpose: combinational round-robin picker, first request at or above rr_ptr with wrap.
// Latency: zero cycles (pure combinational).
// Backpressure: none; caller decides when the grant is consumed.
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int CW     = 2
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CW-1:0]     rr_ptr,
    output logic [CW-1:0]     grant,
    output logic              any_valid
);

    int idx;

    // Scan NUM_CH slots starting at rr_ptr; the first hit wins
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!any_valid && pending[idx]) begin
                any_valid = 1'b1;
                grant     = CW'(idx);
            end
        end
    end

endmodule

// File: rtl/vco_period_scheduler.sv
// Purpose: shares one 555 period engine among NUM_CH VCO voices and holds their CYCLES_HIGH values.
// Latency: pending at t -> eng_start at t+1 -> eng_done at t+1+L -> cycles_high visible at t+2+L.
// Backpressure: one job in flight; new requests wait in IDLE, a silent engine is abandoned after TIMEOUT.
module vco_period_scheduler
    import vco_sched_pkg::*;
#(
    parameter int NUM_CH              = 4,
    parameter int DELTA_THRESH        = 64,
    parameter int REFRESH_TICKS       = 48,
    parameter int TIMEOUT             = 256,
    parameter int DEFAULT_CYCLES_HIGH = 1000
) (
    input  logic                  clk,
    input  logic                  I_RST,
    input  logic                  audio_clk_en,
    input  logic [16*NUM_CH-1:0]  v_control_flat,
    output logic                  eng_start,
    output logic [15:0]           eng_v_control,
    output logic [3:0]            eng_ch,
    input  logic                  eng_done,
    input  logic [31:0]           eng_cycles_high,
    output logic [32*NUM_CH-1:0]  cycles_high_flat,
    output logic [NUM_CH-1:0]     update_strobe,
    output logic                  busy,
    output logic                  err_timeout
);

    localparam int CW = ch_width(NUM_CH);
    localparam int AW = $clog2(REFRESH_TICKS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [15:0]       vc        [NUM_CH];
    logic signed [16:0] diff     [NUM_CH];
    logic [16:0]       mag       [NUM_CH];
    logic [NUM_CH-1:0] pending;
    logic [CW-1:0]     pick;
    logic              pick_vld;

    logic [1:0]        state_q,   state_d;
    logic [CW-1:0]     rr_ptr_q,  rr_ptr_d;
    logic [CW-1:0]     grant_q,   grant_d;
    logic [15:0]       eng_v_q,   eng_v_d;
    logic [3:0]        eng_ch_q,  eng_ch_d;
    logic [TW-1:0]     tmo_q,     tmo_d;
    logic              err_q,     err_d;
    logic [NUM_CH-1:0] strobe_q,  strobe_d;
    logic [31:0]       cyc_q      [NUM_CH];
    logic [31:0]       cyc_d      [NUM_CH];
    logic [15:0]       last_v_q   [NUM_CH];
    logic [15:0]       last_v_d   [NUM_CH];
    logic [AW-1:0]     age_q      [NUM_CH];
    logic [AW-1:0]     age_d      [NUM_CH];
    logic [CW-1:0]     next_ptr;

    // Clamp every voice and flatten the stored high-times
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign vc[gi] = clamp_v(v_control_flat[16*gi +: 16]);
        assign cycles_high_flat[32*gi +: 32] = cyc_q[gi];
    end

    // A voice needs work when its voltage moved far enough or it has gone stale
    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            diff[i]    = $signed({1'b0, vc[i]}) - $signed({1'b0, last_v_q[i]});
            mag[i]     = diff[i][16] ? 17'(-diff[i]) : 17'(diff[i]);
            pending[i] = (mag[i] >= 17'(DELTA_THRESH)) ||
                         (age_q[i] == AW'(REFRESH_TICKS));
        end
    end

    rr_pick #(
        .NUM_CH    (NUM_CH),
        .CW        (CW)
    ) u_pick (
        .pending   (pending),
        .rr_ptr    (rr_ptr_q),
        .grant     (pick),
        .any_valid (pick_vld)
    );

    assign next_ptr = (grant_q == CW'(NUM_CH - 1)) ? '0 : grant_q + CW'(1);

    // Job FSM plus ageing; a result write zeroes age after the tick so the write wins
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        eng_v_d  = eng_v_q;
        eng_ch_d = eng_ch_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        strobe_d = '0;
        cyc_d    = cyc_q;
        last_v_d = last_v_q;
        age_d    = age_q;

        for (int i = 0; i < NUM_CH; i++) begin
            if (audio_clk_en && (age_q[i] != AW'(REFRESH_TICKS))) begin
                age_d[i] = age_q[i] + AW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d  = pick;
                    eng_v_d  = vc[pick];
                    eng_ch_d = 4'(pick);
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done) begin
                    cyc_d[grant_q]    = eng_cycles_high;
                    last_v_d[grant_q] = eng_v_q;
                    age_d[grant_q]    = '0;
                    strobe_d[grant_q] = 1'b1;
                    rr_ptr_d          = next_ptr;
                    state_d           = ST_IDLE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    // Entry, last_v and age untouched so the voice is retried later
                    err_d    = 1'b1;
                    rr_ptr_d = next_ptr;
                    state_d  = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset leaves every voice stale so all are recomputed in order
    always_ff @(posedge clk) begin
        if (I_RST) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            eng_v_q  <= '0;
            eng_ch_q <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            strobe_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cyc_q[i]    <= 32'(DEFAULT_CYCLES_HIGH);
                last_v_q[i] <= '0;
                age_q[i]    <= AW'(REFRESH_TICKS);
            end
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            eng_v_q  <= eng_v_d;
            eng_ch_q <= eng_ch_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            strobe_q <= strobe_d;
            cyc_q    <= cyc_d;
            last_v_q <= last_v_d;
            age_q    <= age_d;
        end
    end

    assign eng_start     = (state_q == ST_ISSUE);
    assign busy          = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign eng_v_control = eng_v_q;
    assign eng_ch        = eng_ch_q;
    assign update_strobe = strobe_q;
    assign err_timeout   = err_q;

endmodule
